fft_host_sequencer: RTL



---
 rtl/fft_host_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fft_host_sequencer.sv
// fft_host_sequencer: bus initiator that loads points into the FFT nodes,
// starts and polls the control counter, then reads every node back and
// streams the results out in input order.

`ifndef GlobalAddrWidth
`define GlobalAddrWidth 16
`endif
`ifndef GlobalDataWidth
`define GlobalDataWidth 16
`endif

module fft_host_sequencer #(
   parameter int unsigned SIZE      = 4,
   parameter int unsigned IDWIDTH   = 8,
   parameter int unsigned NODES     = 4,
   parameter int unsigned BASEID    = 0,
   parameter int unsigned CTRLID    = 8'hF0,
   parameter int unsigned RUNCYCLES = 3,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          Start,
   output logic                          Busy,
   output logic                          Done,
   output logic                          Error,
   input  logic [SIZE:0]                 InData,
   input  logic                          InValid,
   output logic                          InReady,
   output logic [SIZE:0]                 OutData,
   output logic                          OutValid,
   input  logic                          OutReady,
   output logic                          RD,
   output logic                          WR,
   output logic [`GlobalAddrWidth-1:0]   Addr,
   output logic [`GlobalDataWidth-1:0]   BusDataOut,
   input  logic [`GlobalDataWidth-1:0]   BusDataIn
);

   localparam int unsigned AW = `GlobalAddrWidth;
   localparam int unsigned DW = `GlobalDataWidth;
   localparam int unsigned KW = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int unsigned PW = $clog2(TIMEOUT + 1);
   localparam logic [KW-1:0] K_LAST = KW'(NODES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_GETL, S_GETR, S_WSGN, S_RUN, S_POLL,
      S_RDS, S_RDL, S_EMITL, S_RDR, S_EMITR
   } state_t;

   state_t             state, state_nxt;
   logic [KW-1:0]      k;
   logic [PW-1:0]      poll_cnt;
   logic               sl, sr;
   logic [IDWIDTH-1:0] node_base_c;
   logic [IDWIDTH-1:0] addr_id_c;
   logic               poll_zero_c;
   logic               poll_expire_c;
   logic               last_node_c;

   assign node_base_c   = IDWIDTH'(BASEID + 4 * 32'(k));
   assign poll_zero_c   = (BusDataIn == '0);
   assign poll_expire_c = (poll_cnt == PW'(TIMEOUT - 1));
   assign last_node_c   = (k == K_LAST);
   assign Busy          = (state != S_IDLE);
   assign Addr          = AW'(addr_id_c);

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and bus/handshake decode from the current state
   always_comb begin
      state_nxt  = state;
      addr_id_c  = '0;
      RD         = 1'b0;
      WR         = 1'b0;
      BusDataOut = '0;
      InReady    = 1'b0;
      OutValid   = 1'b0;
      case (state)
         S_IDLE: if (Start) state_nxt = S_GETL;
         S_GETL: begin
            InReady                = 1'b1;
            WR                     = InValid;
            addr_id_c              = node_base_c + IDWIDTH'(1);
            BusDataOut[SIZE-1:0]   = InData[SIZE-1:0];
            if (InValid) state_nxt = S_GETR;
         end
         S_GETR: begin
            InReady                = 1'b1;
            WR                     = InValid;
            addr_id_c              = node_base_c + IDWIDTH'(2);
            BusDataOut[SIZE-1:0]   = InData[SIZE-1:0];
            if (InValid) state_nxt = S_WSGN;
         end
         S_WSGN: begin
            WR              = 1'b1;
            addr_id_c       = node_base_c + IDWIDTH'(3);
            BusDataOut[1:0] = {sr, sl};
            state_nxt       = last_node_c ? S_RUN : S_GETL;
         end
         S_RUN: begin
            WR         = 1'b1;
            addr_id_c  = IDWIDTH'(CTRLID);
            BusDataOut = DW'(RUNCYCLES);
            state_nxt  = S_POLL;
         end
         S_POLL: begin
            RD        = 1'b1;
            addr_id_c = IDWIDTH'(CTRLID);
            if (poll_zero_c || poll_expire_c) state_nxt = S_RDS;
         end
         S_RDS: begin
            RD        = 1'b1;
            addr_id_c = node_base_c + IDWIDTH'(3);
            state_nxt = S_RDL;
         end
         S_RDL: begin
            RD        = 1'b1;
            addr_id_c = node_base_c + IDWIDTH'(1);
            state_nxt = S_EMITL;
         end
         S_EMITL: begin
            OutValid = 1'b1;
            if (OutReady) state_nxt = S_RDR;
         end
         S_RDR: begin
            RD        = 1'b1;
            addr_id_c = node_base_c + IDWIDTH'(2);
            state_nxt = S_EMITR;
         end
         S_EMITR: begin
            OutValid = 1'b1;
            if (OutReady) state_nxt = last_node_c ? S_IDLE : S_RDS;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Node index, sign latches, poll counter, output data and status flags
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         k        <= '0;
         sl       <= 1'b0;
         sr       <= 1'b0;
         poll_cnt <= '0;
         OutData  <= '0;
         Done     <= 1'b0;
         Error    <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            S_IDLE: if (Start) begin
               k     <= '0;
               Error <= 1'b0;
            end
            S_GETL: if (InValid) sl <= InData[SIZE];
            S_GETR: if (InValid) sr <= InData[SIZE];
            S_WSGN: k <= last_node_c ? '0 : k + 1'b1;
            S_RUN:  poll_cnt <= '0;
            S_POLL: if (!poll_zero_c) begin
               poll_cnt <= poll_cnt + 1'b1;
               if (poll_expire_c) Error <= 1'b1;
            end
            S_RDS: begin
               sl <= BusDataIn[0];
               sr <= BusDataIn[1];
            end
            S_RDL: OutData <= {sl, BusDataIn[SIZE-1:0]};
            S_RDR: OutData <= {sr, BusDataIn[SIZE-1:0]};
            S_EMITR: if (OutReady) begin
               if (last_node_c) begin
                  k    <= '0;
                  Done <= 1'b1;
               end else begin
                  k <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
